kugelblitz_capture: RTL
=======================

Name: kugelblitz_capture

Overview:
- Passive tap on one 512-bit AXI-stream path (qsfp tx or rx) that captures a 32-bit field at a programmable byte offset of every frame.
- Exposes captured data, status and frame/capture counters through an AXI-Lite slave register file.
- Read-side counterpart of the offload byte-patch path: software reads fields out of frames instead of writing them in.
- The stream passes through unmodified, with zero latency.

Parameters:
- DATA_WIDTH, 512, stream width; any other value is a fatal elaboration error.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width; KEEP_WIDTH*8 != DATA_WIDTH is a fatal elaboration error.
- USER_WIDTH, 1, tuser width.
- AXIL_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- AXIL_ADDR_WIDTH, 32, AXI-Lite address width; only addr[7:2] is decoded.
- AXIL_STRB_WIDTH, AXIL_DATA_WIDTH/8, write strobe width.
- OFFSET_WIDTH, 14, byte-offset register width (frames up to 16 KiB).

Ports:
- clk  in  1  single clock for stream and AXI-Lite.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  upstream stream.
- s_axis_tready  out  1  equals m_axis_tready.
- m_axis_tdata/tkeep/tvalid/tlast/tuser  out  same widths  combinational copies of s_axis_*.
- m_axis_tready  in  1  downstream ready.
- s_axil_awaddr/awprot/awvalid  in  AXIL_ADDR_WIDTH/3/1  write address channel.
- s_axil_awready  out  1.
- s_axil_wdata/wstrb/wvalid  in  32/4/1  write data channel.
- s_axil_wready  out  1.
- s_axil_bresp/bvalid  out  2/1.
- s_axil_bready  in  1.
- s_axil_araddr/arprot/arvalid  in  AXIL_ADDR_WIDTH/3/1  read address channel.
- s_axil_arready  out  1.
- s_axil_rdata/rresp/rvalid  out  32/2/1.
- s_axil_rready  in  1.

Behaviour:
- Beat: s_axis_tvalid && m_axis_tready.
- beat_cnt increments on each beat and returns to 0 on a tlast beat. Reset value 0; a reset mid-frame makes the next beat a frame start.
- Offset sampling:
  - Effective offset = OFFSET register when beat_cnt==0, else the shadow copy.
  - The shadow copy is loaded on the first beat of each frame.
  - A mid-frame OFFSET write therefore applies from the next frame.
  - Offset bits [1:0] are ignored (32-bit aligned, so a field never straddles a beat). Word index = off[13:6], lane = off[5:2].
- Capture:
  - Condition: ENABLE, beat, beat_cnt==word index, and tkeep[lane*4 +: 4]==4'hF.
  - CAPTURE_DATA <= tdata[lane*32 +: 32], little-endian (byte at the offset lands in [7:0]).
  - VALID set. OVERRUN set if VALID was already 1. CAPTURE_COUNT++.
  - Register contents are visible one cycle after the beat.
- A frame whose tlast beat completes without a capture (and ENABLE=1) increments SHORT_COUNT.
- FRAME_COUNT increments on every tlast beat when ENABLE=1.
- All counters are 32-bit and wrap 0xFFFFFFFF -> 0.
- Register map (byte address, reset value):
  - 0x00 CTRL, 0: bit0 ENABLE (rw); bit1 CLEAR (write-1 pulse zeroes all three counters, reads 0).
  - 0x04 OFFSET, 0: rw, [OFFSET_WIDTH-1:0].
  - 0x08 CAPTURE_DATA, 0: ro; a completed read clears VALID.
  - 0x0C STATUS, 0: bit0 VALID (ro); bit1 OVERRUN (sticky, write-1-to-clear).
  - 0x10 FRAME_COUNT, 0x14 CAPTURE_COUNT, 0x18 SHORT_COUNT: ro.
  - Any other address reads 0; writes to it are ignored. All responses are OKAY (2'b00).
- wstrb honoured per byte on rw registers.
- Simultaneous events:
  - Capture and CAPTURE_DATA read completing in the same cycle: capture wins, VALID stays 1, the read returns old data.
  - CLEAR and counter increment in the same cycle: CLEAR wins, counter = 0.
  - OVERRUN set and write-1-clear in the same cycle: set wins.
- AXI-Lite write:
  - awready and wready are pulsed together for one cycle when awvalid && wvalid && !bvalid.
  - Register updates the next cycle.
  - bvalid rises the cycle after the handshake and is held until bready.
- AXI-Lite read:
  - arready is pulsed when arvalid && !rvalid.
  - rdata is registered and rvalid rises the next cycle, held until rready.
  - rdata is stable while rvalid=1.
- One outstanding transaction per channel; the read and write channels are independent.
- Reset values: all AXI-Lite outputs and all registers 0. Stream outputs follow their inputs, including during reset.

Test Plan:
- ENABLE=1, OFFSET=0x48, three 2-beat frames with byte 0x48+i = 0x10+i, full tkeep -> CAPTURE_DATA=0x13121110, VALID=1, OVERRUN=1 after the 2nd frame, FRAME_COUNT=3, CAPTURE_COUNT=3.
- OFFSET=0x7D (treated as 0x7C) -> data from beat 1, lane 15; 1-beat frame -> SHORT_COUNT=1, CAPTURE_COUNT=0.
- tkeep on the target lane 4'h7 -> no capture, SHORT_COUNT++.
- Capture on the same clock as a CAPTURE_DATA read completes -> read returns previous value, VALID remains 1.
- OFFSET written mid-frame (0x04 -> 0x08) -> current frame captures bytes 4..7, next frame bytes 8..11.
- rst_n pulsed mid-frame, then a fresh 1-beat frame with OFFSET=0 -> captures that frame's bytes 0..3. Throughout, m_axis_tready toggling 50% -> m_axis equals s_axis every cycle with no drops.

Source files
------------

// File: rtl/kugelblitz_capture.sv
// kugelblitz_capture: passive tap on a 512-bit AXI-stream path. Grabs one
// 32-bit little-endian field per frame at a programmable byte offset and
// exposes it, plus frame/capture/short counters, over an AXI-Lite slave.
// The stream itself passes straight through with no added latency.
module kugelblitz_capture #(
   parameter int DATA_WIDTH      = 512,
   parameter int KEEP_WIDTH      = DATA_WIDTH/8,
   parameter int USER_WIDTH      = 1,
   parameter int AXIL_DATA_WIDTH = 32,
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
   parameter int OFFSET_WIDTH    = 14
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   input  logic [USER_WIDTH-1:0]      s_axis_tuser,
   output logic                       s_axis_tready,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   output logic [USER_WIDTH-1:0]      m_axis_tuser,
   input  logic                       m_axis_tready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]                 s_axil_awprot,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]                 s_axil_arprot,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready
);

   if (DATA_WIDTH != 512) begin : g_bad_data_width
      $fatal(1, "kugelblitz_capture: DATA_WIDTH must be 512");
   end
   if (KEEP_WIDTH*8 != DATA_WIDTH) begin : g_bad_keep_width
      $fatal(1, "kugelblitz_capture: KEEP_WIDTH*8 must equal DATA_WIDTH");
   end
   if (AXIL_DATA_WIDTH != 32) begin : g_bad_axil_width
      $fatal(1, "kugelblitz_capture: AXIL_DATA_WIDTH must be 32");
   end

   // word index covers the offset bits above the 64-byte beat; the beat
   // counter carries one extra bit so it saturates beyond any word index
   localparam int WW  = OFFSET_WIDTH - 6;
   localparam int BCW = WW + 1;

   localparam logic [5:0] A_CTRL = 6'h00, A_OFFSET = 6'h01, A_DATA  = 6'h02,
                          A_STAT = 6'h03, A_FRAME  = 6'h04, A_CAPT  = 6'h05,
                          A_SHORT = 6'h06;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tvalid = s_axis_tvalid;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tuser  = s_axis_tuser;
   assign s_axis_tready = m_axis_tready;

   logic                    enable_q, valid_q, overrun_q, hit_q, bvalid_q, rvalid_q, rd_data_q;
   logic [OFFSET_WIDTH-1:0] offset_q, shadow_q, eff_off;
   logic [BCW-1:0]          beat_cnt_q;
   logic [31:0]             cap_data_q, frame_cnt_q, capt_cnt_q, short_cnt_q, rdata_q;
   logic [31:0]             strb_mask, off_wr, rd_mux;
   logic [WW-1:0]           word_idx;
   logic [3:0]              lane, lane_keep;
   logic [31:0]             lane_data;
   logic                    beat, capture, frame_inc, short_inc;
   logic                    aw_hs, ar_hs, clear_pulse, ovr_w1c, data_read_done;

   assign beat      = s_axis_tvalid & m_axis_tready;
   assign eff_off   = (beat_cnt_q == '0) ? offset_q : shadow_q;
   assign word_idx  = eff_off[OFFSET_WIDTH-1:6];
   assign lane      = eff_off[5:2];
   assign lane_keep = s_axis_tkeep[{lane, 2'b00} +: 4];
   assign lane_data = s_axis_tdata[{lane, 5'b00000} +: 32];
   assign capture   = enable_q & beat & (beat_cnt_q == {1'b0, word_idx}) & (lane_keep == 4'hF);
   assign frame_inc = enable_q & beat & s_axis_tlast;
   assign short_inc = frame_inc & ~(hit_q | capture);

   assign aw_hs          = s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
   assign s_axil_awready = aw_hs;
   assign s_axil_wready  = aw_hs;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = 2'b00;
   assign ar_hs          = s_axil_arvalid & ~rvalid_q;
   assign s_axil_arready = ar_hs;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = 2'b00;

   assign clear_pulse    = aw_hs & (s_axil_awaddr[7:2] == A_CTRL) & s_axil_wstrb[0] & s_axil_wdata[1];
   assign ovr_w1c        = aw_hs & (s_axil_awaddr[7:2] == A_STAT) & s_axil_wstrb[0] & s_axil_wdata[1];
   assign data_read_done = rvalid_q & s_axil_rready & rd_data_q;

   // byte-strobe merge of a write into the offset register
   always_comb begin
      strb_mask = '0;
      for (int i = 0; i < 4; i++) strb_mask[i*8 +: 8] = {8{s_axil_wstrb[i]}};
      off_wr = ({{(32-OFFSET_WIDTH){1'b0}}, offset_q} & ~strb_mask) | (s_axil_wdata & strb_mask);
   end

   // register read mux; unmapped addresses read zero
   always_comb begin
      rd_mux = '0;
      case (s_axil_araddr[7:2])
         A_CTRL:   rd_mux = {31'b0, enable_q};
         A_OFFSET: rd_mux = {{(32-OFFSET_WIDTH){1'b0}}, offset_q};
         A_DATA:   rd_mux = cap_data_q;
         A_STAT:   rd_mux = {30'b0, overrun_q, valid_q};
         A_FRAME:  rd_mux = frame_cnt_q;
         A_CAPT:   rd_mux = capt_cnt_q;
         A_SHORT:  rd_mux = short_cnt_q;
         default:  rd_mux = '0;
      endcase
   end

   // frame tracking: beat position, offset shadow, per-frame hit flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         shadow_q   <= '0;
         hit_q      <= 1'b0;
      end else if (beat) begin
         if (beat_cnt_q == '0) shadow_q <= offset_q;
         if (s_axis_tlast) begin
            beat_cnt_q <= '0;
            hit_q      <= 1'b0;
         end else begin
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + BCW'(1);
            if (capture) hit_q <= 1'b1;
         end
      end
   end

   // captured field and status flags; a capture beats a same-cycle read clear or W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_data_q <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (capture) begin
            cap_data_q <= lane_data;
            valid_q    <= 1'b1;
         end else if (data_read_done) begin
            valid_q    <= 1'b0;
         end
         if (capture && valid_q) overrun_q <= 1'b1;
         else if (ovr_w1c)       overrun_q <= 1'b0;
      end
   end

   // event counters; CLEAR takes priority over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         capt_cnt_q  <= '0;
         short_cnt_q <= '0;
      end else if (clear_pulse) begin
         frame_cnt_q <= '0;
         capt_cnt_q  <= '0;
         short_cnt_q <= '0;
      end else begin
         if (frame_inc) frame_cnt_q <= frame_cnt_q + 32'd1;
         if (capture)   capt_cnt_q  <= capt_cnt_q + 32'd1;
         if (short_inc) short_cnt_q <= short_cnt_q + 32'd1;
      end
   end

   // AXI-Lite write channel and rw registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bvalid_q <= 1'b0;
         enable_q <= 1'b0;
         offset_q <= '0;
      end else begin
         if (aw_hs) begin
            bvalid_q <= 1'b1;
            if (s_axil_awaddr[7:2] == A_CTRL && s_axil_wstrb[0]) enable_q <= s_axil_wdata[0];
            if (s_axil_awaddr[7:2] == A_OFFSET) offset_q <= off_wr[OFFSET_WIDTH-1:0];
         end else if (s_axil_bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // AXI-Lite read channel; rdata is frozen while rvalid is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rd_data_q <= 1'b0;
      end else if (ar_hs) begin
         rvalid_q  <= 1'b1;
         rdata_q   <= rd_mux;
         rd_data_q <= (s_axil_araddr[7:2] == A_DATA);
      end else if (s_axil_rready) begin
         rvalid_q  <= 1'b0;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr,
                        off_wr, eff_off[1:0]};

endmodule
